seq_scan_arbiter: RTL and testbench

- Shared serial pattern-scan engine with a round-robin arbiter in front of it.
- Up to N requesters each present a WIDTH-bit word.
- The arbiter grants one requester, shifts its word MSB-first through an embedded Moore detector, counts detections, and returns the count with a one-cycle done/ack.
- The detector flags every bit position where the last three serial bits are 101 or 110, with overlap.
- The block sits between the requester clients and the detector, so only one job owns the detector at a time.

---
 rtl/seq_scan_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_seq_scan_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin arbiter in front of a shared serial pattern-scan engine.
// The winning requester's word is shifted MSB-first through a Moore detector that
// flags every 3-bit window equal to 101 or 110 (overlapping). The hit count is
// returned with a one-cycle done pulse and a one-hot ack to the served requester.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   req       level request per requester, held until ack
//   req_data  flat job bus, requester i owns [i*WIDTH +: WIDTH]
//   busy      high whenever the control FSM is not idle
//   done      one-cycle pulse, result valid
//   ack       one-hot ack for the served requester, coincident with done
//   gnt_id    index of the current/last served requester
//   hit_cnt   detection count, valid while done=1
module seq_scan_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH),
    parameter int unsigned ID_W  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         ack,
    output logic [ID_W-1:0]      gnt_id,
    output logic [CNT_W-1:0]     hit_cnt
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        D_IDLE,
        D_S1,
        D_S11,
        D_S10,
        D_S101,
        D_S110
    } det_t;

    state_t            state;
    state_t            state_nxt;
    det_t              det_state;
    det_t              det_nxt;
    logic              det_out;
    logic [WIDTH-1:0]  shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic [WIDTH-1:0]  sel_word;
    logic              grant;
    logic              busy_nxt;
    logic              done_nxt;
    logic [N-1:0]      ack_nxt;

    // Detector transition function; unused encodings fall back to Idle.
    function automatic det_t det_step(input det_t s, input logic b);
        det_t n;
        n = D_IDLE;
        case (s)
            D_IDLE: n = b ? D_S1   : D_IDLE;
            D_S1:   n = b ? D_S11  : D_S10;
            D_S11:  n = b ? D_S11  : D_S110;
            D_S10:  n = b ? D_S101 : D_IDLE;
            D_S101: n = b ? D_S11  : D_S10;
            D_S110: n = b ? D_S101 : D_IDLE;
            default: n = D_IDLE;
        endcase
        return n;
    endfunction

    assign det_out = (det_state == D_S101) || (det_state == D_S110);
    assign grant   = (state == ST_IDLE) && (|req);

    // Round-robin pick: first set request searching upward from last_grant+1.
    always_comb begin
        win_id = last_grant;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = ID_W'((32'(last_grant) + i) % N);
            if (!found && req[cand]) begin
                win_id = cand;
                found  = 1'b1;
            end
        end
    end

    // Mux out the winner's word.
    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_word = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control FSM next state and next values of the registered outputs.
    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        ack_nxt   = '0;
        case (state)
            ST_IDLE:  if (|req) state_nxt = ST_SHIFT;
            ST_SHIFT: if (bit_idx == LAST_IDX) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_DONE);
        if (done_nxt) begin
            ack_nxt = N'(1) << gnt_id;
        end
    end

    // Detector next state: forced to Idle on grant, stepped only while shifting.
    always_comb begin
        det_nxt = det_state;
        if (grant) begin
            det_nxt = D_IDLE;
        end else if (state == ST_SHIFT) begin
            det_nxt = det_step(det_state, shreg[WIDTH-1]);
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            ack  <= '0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            ack  <= ack_nxt;
        end
    end

    // Job datapath: word latch/shift, bit index, grant bookkeeping, hit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_state  <= D_IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            last_grant <= ID_W'(N - 1);
            gnt_id     <= '0;
            hit_cnt    <= '0;
        end else begin
            det_state <= det_nxt;
            if (grant) begin
                shreg      <= sel_word;
                bit_idx    <= '0;
                gnt_id     <= win_id;
                last_grant <= win_id;
                hit_cnt    <= '0;
            end else begin
                if (state == ST_SHIFT) begin
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + IDX_W'(1);
                end
                // det_out lags the fed bit by one cycle, so DRAIN catches the final window.
                if (((state == ST_SHIFT) || (state == ST_DRAIN)) && det_out) begin
                    hit_cnt <= hit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Self-checking bench for seq_scan_arbiter (N=4, WIDTH=8).
module tb_seq_scan_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned ID_W  = 2;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req;
    logic [N*WIDTH-1:0]  req_data;
    logic                busy;
    logic                done;
    logic [N-1:0]        ack;
    logic [ID_W-1:0]     gnt_id;
    logic [CNT_W-1:0]    hit_cnt;

    seq_scan_arbiter #(
        .N     (N),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .ID_W  (ID_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .busy     (busy),
        .done     (done),
        .ack      (ack),
        .gnt_id   (gnt_id),
        .hit_cnt  (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [7:0]  data;
        int          exp_lat;
        int          exp_ack;
        int          exp_gnt;
        int          exp_cnt;
    } vec_t;

    int n_cmp;
    int n_err;

    int   done_cyc [8];
    int   ack_log  [8];
    int   cnt_log  [8];
    int   gid_log  [8];
    logic busy_log [100];
    int   n_got;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Observe up to max_cyc cycles on the falling edge, logging done events.
    task automatic collect(input int max_cyc, input int want);
        n_got = 0;
        for (int n = 1; n <= max_cyc && n_got < want; n++) begin
            @(negedge clk);
            busy_log[n] = busy;
            if (done) begin
                done_cyc[n_got] = n;
                ack_log[n_got]  = int'(ack);
                cnt_log[n_got]  = int'(hit_cnt);
                gid_log[n_got]  = int'(gnt_id);
                n_got++;
            end
        end
        chk("done_events", n_got, want);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        int   busy_bad;
        int   early_done;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{2, 8'b10110100, 10, 4'b0100, 2, 3};
        vecs[1] = '{0, 8'hFF,       10, 4'b0001, 0, 0};
        vecs[2] = '{1, 8'b10101010, 10, 4'b0010, 1, 3};
        vecs[3] = '{3, 8'b11011011, 10, 4'b1000, 3, 4};
        vecs[4] = '{0, 8'h00,       10, 4'b0001, 0, 0};
        vecs[5] = '{2, 8'b01100110, 10, 4'b0100, 2, 2};
        vecs[6] = '{1, 8'b11111110, 10, 4'b0010, 1, 1};
        vecs[7] = '{3, 8'b10000001, 10, 4'b1000, 3, 0};
        vecs[8] = '{0, 8'b01011011, 10, 4'b0001, 0, 3};

        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy",    int'(busy),    0);
        chk("rst_done",    int'(done),    0);
        chk("rst_ack",     int'(ack),     0);
        chk("rst_gnt_id",  int'(gnt_id),  0);
        chk("rst_hit_cnt", int'(hit_cnt), 0);

        @(negedge clk);
        rst = 1'b1;

        // Single-requester jobs from the vector table.
        for (int v = 0; v < 9; v++) begin
            req = '0;
            req[vecs[v].id] = 1'b1;
            req_data[vecs[v].id*WIDTH +: WIDTH] = vecs[v].data;
            collect(20, 1);
            req = '0;
            chk("vec_latency", done_cyc[0], vecs[v].exp_lat);
            chk("vec_ack",     ack_log[0],  vecs[v].exp_ack);
            chk("vec_gnt_id",  gid_log[0],  vecs[v].exp_gnt);
            chk("vec_hit_cnt", cnt_log[0],  vecs[v].exp_cnt);
            busy_bad = 0;
            for (int n = 1; n <= 10; n++) if (busy_log[n] !== 1'b1) busy_bad++;
            chk("vec_busy_high", busy_bad, 0);
            @(negedge clk);
            chk("vec_idle_busy", int'(busy), 0);
            chk("vec_idle_done", int'(done), 0);
        end

        // All four requesters held from reset release: strict round robin.
        enter_reset();
        req_data[0*WIDTH +: WIDTH] = 8'b10110100;
        req_data[1*WIDTH +: WIDTH] = 8'hFF;
        req_data[2*WIDTH +: WIDTH] = 8'b11011011;
        req_data[3*WIDTH +: WIDTH] = 8'b10101010;
        req = 4'b1111;
        rst = 1'b1;
        collect(70, 5);
        req = '0;
        chk("rr4_ack0", ack_log[0], 4'b0001);
        chk("rr4_ack1", ack_log[1], 4'b0010);
        chk("rr4_ack2", ack_log[2], 4'b0100);
        chk("rr4_ack3", ack_log[3], 4'b1000);
        chk("rr4_ack4", ack_log[4], 4'b0001);
        chk("rr4_cnt0", cnt_log[0], 3);
        chk("rr4_cnt1", cnt_log[1], 0);
        chk("rr4_cnt2", cnt_log[2], 4);
        chk("rr4_cnt3", cnt_log[3], 3);
        chk("rr4_cnt4", cnt_log[4], 3);
        chk("rr4_first_done", done_cyc[0], 10);
        for (int k = 1; k < 5; k++) chk("rr4_done_spacing", done_cyc[k] - done_cyc[k-1], 11);
        busy_bad = 0;
        for (int n = 1; n <= 54; n++) if (busy_log[n] !== ((n % 11) != 0)) busy_bad++;
        chk("rr4_busy_pattern", busy_bad, 0);

        // Drop req and change data mid-job: latched word still used, ack still sent.
        @(negedge clk);
        req_data[1*WIDTH +: WIDTH] = 8'b01100110;
        req = 4'b0010;
        repeat (2) @(negedge clk);
        req = '0;
        req_data[1*WIDTH +: WIDTH] = 8'hFF;
        collect(20, 1);
        chk("drop_latency", done_cyc[0] + 2, 10);
        chk("drop_ack",     ack_log[0], 4'b0010);
        chk("drop_hit_cnt", cnt_log[0], 2);

        // Reset during the 4th SHIFT cycle, then rerun.
        @(negedge clk);
        req_data[2*WIDTH +: WIDTH] = 8'b10110100;
        req = 4'b0100;
        early_done = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (done) early_done++;
        end
        chk("mid_busy_before", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",    int'(busy),    0);
        chk("mid_rst_done",    int'(done),    0);
        chk("mid_rst_ack",     int'(ack),     0);
        chk("mid_rst_gnt_id",  int'(gnt_id),  0);
        chk("mid_rst_hit_cnt", int'(hit_cnt), 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done) early_done++;
        end
        chk("mid_no_done", early_done, 0);
        req_data[0*WIDTH +: WIDTH] = 8'b11011011;
        req = 4'b0101;
        rst = 1'b1;
        collect(30, 2);
        req = '0;
        chk("rerun_ack0",  ack_log[0],  4'b0001);
        chk("rerun_cnt0",  cnt_log[0],  4);
        chk("rerun_done0", done_cyc[0], 10);
        chk("rerun_ack1",  ack_log[1],  4'b0100);
        chk("rerun_cnt1",  cnt_log[1],  3);
        chk("rerun_done1", done_cyc[1], 21);

        // Requesters 1 and 3; 1 keeps requesting after its ack and drops to lowest priority.
        enter_reset();
        req_data[1*WIDTH +: WIDTH] = 8'b10101010;
        req_data[3*WIDTH +: WIDTH] = 8'b11111110;
        req = 4'b1010;
        rst = 1'b1;
        collect(50, 3);
        req = '0;
        chk("rr13_ack0", ack_log[0], 4'b0010);
        chk("rr13_ack1", ack_log[1], 4'b1000);
        chk("rr13_ack2", ack_log[2], 4'b0010);
        chk("rr13_gnt1", gid_log[1], 3);
        chk("rr13_cnt0", cnt_log[0], 3);
        chk("rr13_cnt1", cnt_log[1], 1);
        chk("rr13_cnt2", cnt_log[2], 3);
        chk("rr13_done2", done_cyc[2], 32);

        @(negedge clk);
        chk("final_idle_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
